// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU share arbiter: op codes, control state
// encodings and the slow-op classifier used by both the ALU and the arbiter.
package alu_share_arbiter_pkg;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_SLL  = 5'd5;
  localparam logic [4:0] OP_SRL  = 5'd6;
  localparam logic [4:0] OP_SRA  = 5'd7;
  localparam logic [4:0] OP_SLT  = 5'd8;
  localparam logic [4:0] OP_SLTU = 5'd9;
  localparam logic [4:0] OP_MUL  = 5'd10;
  localparam logic [4:0] OP_REM  = 5'd11;
  localparam logic [4:0] OP_REMU = 5'd12;
  localparam logic [4:0] OP_PASS = 5'd13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Ops that get the multi-cycle slot so the ALU is not timed as single-cycle.
  function automatic logic is_slow_op(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// ALUCPU: combinational core ALU shared by the arbiter.
//   op   : op code (unknown codes give 0 with ovf=0)
//   a, b : operands
//   y    : result
//   zero : y == 0
//   ovf  : signed overflow for ADD/SUB, 0 otherwise
// REM/REMU by zero return a; signed REM of MIN by -1 returns 0.
module ALUCPU
  import alu_share_arbiter_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [4:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] y,
  output logic         zero,
  output logic         ovf
);

  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [SW-1:0] sh;
  logic          b_zero, rem_ovf;
  logic [N-1:0]  rem_div, remu_div, rems_q, remu_q;

  assign sh       = b[SW-1:0];
  assign b_zero   = (b == '0);
  assign rem_ovf  = (a == {1'b1, {(N-1){1'b0}}}) && (&b);
  // Divisors are forced to 1 in the special cases so the divider never sees
  // an undefined operation; the real result is selected below.
  assign rem_div  = (b_zero || rem_ovf) ? {{(N-1){1'b0}}, 1'b1} : b;
  assign remu_div = b_zero ? {{(N-1){1'b0}}, 1'b1} : b;
  assign rems_q   = $signed(a) % $signed(rem_div);
  assign remu_q   = a % remu_div;

  always_comb begin
    y   = '0;
    ovf = 1'b0;
    case (op)
      OP_ADD: begin
        y   = a + b;
        ovf = (a[N-1] == b[N-1]) && (y[N-1] != a[N-1]);
      end
      OP_SUB: begin
        y   = a - b;
        ovf = (a[N-1] != b[N-1]) && (y[N-1] != a[N-1]);
      end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SLL:  y = a << sh;
      OP_SRL:  y = a >> sh;
      OP_SRA:  y = $signed(a) >>> sh;
      OP_SLT:  y = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: y = {{(N-1){1'b0}}, (a < b)};
      OP_MUL:  y = a * b;
      OP_REM:  y = b_zero ? a : (rem_ovf ? '0 : rems_q);
      OP_REMU: y = b_zero ? a : remu_q;
      OP_PASS: y = a;
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/alu_share_arbiter_rr_pick.sv
// rr_pick: round-robin priority picker.
//   valid : request vector
//   ptr   : index with highest priority this cycle (always < NREQ)
//   grant : one-hot winner (zero when nothing valid)
//   idx   : winner index
//   any   : at least one valid
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  always_comb begin
    logic [IW:0] s;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    s     = '0;
    // Scan ptr, ptr+1, ... with a manual modulo so non power-of-two NREQ works.
    for (int k = 0; k < NREQ; k++) begin
      s = {1'b0, ptr} + (IW+1)'(k);
      if (s >= (IW+1)'(NREQ)) s = s - (IW+1)'(NREQ);
      if (!any && valid[s[IW-1:0]]) begin
        any               = 1'b1;
        grant[s[IW-1:0]]  = 1'b1;
        idx               = s[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one ALUCPU between NREQ requesters.
//   clock, reset          : single clock, synchronous active-high reset
//   req_valid/req_ready   : per-requester request handshake (ready one-hot)
//   req_op/req_a/req_b    : flattened per-requester op (5b) and operands (N)
//   rsp_valid/rsp_ready   : per-requester response handshake (valid one-hot)
//   rsp_out/zero/ovf      : registered result, held until the owner consumes it
// Fast ops respond one cycle after accept; MUL/REM/REMU after SLOW_LAT cycles.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int N        = 32,
  parameter int NREQ     = 2,
  parameter int SLOW_LAT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*5-1:0] req_op,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [N-1:0]      rsp_out,
  output logic              rsp_zero,
  output logic              rsp_ovf
);

  localparam int IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW      = (SLOW_LAT > 1) ? $clog2(SLOW_LAT) : 1;
  localparam bit SLOW_EN = (SLOW_LAT > 1);

  typedef struct packed {
    logic [4:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
  } opnd_t;

  opnd_t [NREQ-1:0] lane_req;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign lane_req[i] = {req_op[5*i +: 5], req_a[N*i +: N], req_b[N*i +: N]};
  end

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   rr_ptr, owner, win_idx;
  logic [NREQ-1:0] grant, owner_oh;
  logic            win_any, hs, can_accept, accept, acc_slow, busy_done, load_res;
  opnd_t           opnd, alu_in;
  logic [N-1:0]    alu_y;
  logic            alu_zero, alu_ovf;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  assign hs         = (state == ST_DONE) && rsp_ready[owner];
  assign can_accept = (state == ST_IDLE) || hs;
  assign accept     = can_accept && win_any;
  assign acc_slow   = SLOW_EN && is_slow_op(lane_req[win_idx].op);
  assign busy_done  = (state == ST_BUSY) && (cnt == CW'(1));
  assign load_res   = (accept && !acc_slow) || busy_done;
  assign owner_oh   = NREQ'(1) << owner;

  // Fast ops are computed from the live winner so the result can be loaded at
  // the accept edge; slow ops finish from the latched operands.
  assign alu_in = accept ? lane_req[win_idx] : opnd;

  ALUCPU #(.N(N)) u_alu (
    .op   (alu_in.op),
    .a    (alu_in.a),
    .b    (alu_in.b),
    .y    (alu_y),
    .zero (alu_zero),
    .ovf  (alu_ovf)
  );

  // state register
  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // next state
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept) state_nx = acc_slow ? ST_BUSY : ST_DONE;
      ST_BUSY: if (cnt == CW'(1)) state_nx = ST_DONE;
      ST_DONE: if (hs) state_nx = accept ? (acc_slow ? ST_BUSY : ST_DONE) : ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // outputs
  always_comb begin
    req_ready = '0;
    if (accept) req_ready = grant;
  end

  // control: operands, owner, round-robin pointer, slow-op counter
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt    <= '0;
      rr_ptr <= '0;
      owner  <= '0;
      opnd   <= '0;
    end else if (accept) begin
      opnd   <= lane_req[win_idx];
      owner  <= win_idx;
      rr_ptr <= (win_idx == IW'(NREQ-1)) ? '0 : win_idx + 1'b1;
      cnt    <= acc_slow ? CW'(SLOW_LAT-1) : '0;
    end else if (state == ST_BUSY) begin
      cnt    <= cnt - 1'b1;
    end
  end

  // result registers; rsp_out keeps its last value once the response is taken
  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_valid <= '0;
      rsp_out   <= '0;
      rsp_zero  <= 1'b0;
      rsp_ovf   <= 1'b0;
    end else if (load_res) begin
      rsp_valid <= accept ? grant : owner_oh;
      rsp_out   <= alu_y;
      rsp_zero  <= alu_zero;
      rsp_ovf   <= alu_ovf;
    end else if (hs) begin
      rsp_valid <= '0;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // two-requester instance, SLOW_LAT=4
  logic [1:0]  v2 = '0, rdy2, vld2, rr2 = '0;
  logic [9:0]  op2 = '0;
  logic [63:0] a2 = '0, b2 = '0;
  logic [31:0] out2;
  logic        zero2, ovf2;
  // three-requester instance, SLOW_LAT=2
  logic [2:0]  v3 = '0, rdy3, vld3, rr3 = 3'b111;
  logic [14:0] op3 = '0;
  logic [95:0] a3 = '0, b3 = '0;
  logic [31:0] out3;
  logic        zero3, ovf3;

  alu_share_arbiter #(.N(32), .NREQ(2), .SLOW_LAT(4)) dut (
    .clock(clk), .reset(reset), .req_valid(v2), .req_ready(rdy2), .req_op(op2),
    .req_a(a2), .req_b(b2), .rsp_valid(vld2), .rsp_ready(rr2), .rsp_out(out2),
    .rsp_zero(zero2), .rsp_ovf(ovf2));

  alu_share_arbiter #(.N(32), .NREQ(3), .SLOW_LAT(2)) dut3 (
    .clock(clk), .reset(reset), .req_valid(v3), .req_ready(rdy3), .req_op(op3),
    .req_a(a3), .req_b(b3), .rsp_valid(vld3), .rsp_ready(rr3), .rsp_out(out3),
    .rsp_zero(zero3), .rsp_ovf(ovf3));

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic void mdl_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] y, output bit z, output bit o);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s  = 0;
    y  = 0;
    o  = 0;
    case (op)
      OP_ADD:  begin s = sa + sb; y = s[31:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      OP_SUB:  begin s = sa - sb; y = s[31:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SLL:  y = a << b[4:0];
      OP_SRL:  y = a >> b[4:0];
      OP_SRA:  y = 32'($signed(a) >>> b[4:0]);
      OP_SLT:  y = (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU: y = (a < b) ? 32'd1 : 32'd0;
      OP_MUL:  y = a * b;
      OP_REM:  if (b == 0) y = a; else begin s = sa % sb; y = s[31:0]; end
      OP_REMU: y = (b == 0) ? a : a % b;
      OP_PASS: y = a;
      default: y = 0;
    endcase
    z = (y == 0);
  endfunction

  typedef struct {
    int          ptr;
    bit          vis;     // response presented this cycle
    int          owner;
    int          cnt;     // cycles until an in-flight slow result appears
    logic [31:0] out, p_out;
    bit          zero, ovf, p_zero, p_ovf;
  } mdl_t;

  function automatic mdl_t mreset();
    mdl_t m;
    m.ptr = 0; m.vis = 0; m.owner = 0; m.cnt = 0;
    m.out = 0; m.p_out = 0; m.zero = 0; m.ovf = 0; m.p_zero = 0; m.p_ovf = 0;
    return m;
  endfunction

  // One clock of the model: expected req_ready now, state after the edge.
  function automatic void mstep(input mdl_t mi, input int n, input int slat, input logic [2:0] v,
                                input logic [14:0] ops, input logic [95:0] a, input logic [95:0] b,
                                input logic [2:0] rr, output mdl_t mo, output logic [2:0] er);
    mdl_t m;
    bit free, take;
    int win, j, lat;
    logic [4:0] op;
    logic [31:0] y;
    bit z, o;
    m = mi;
    free = (m.cnt == 0 && !m.vis) || (m.vis && rr[m.owner]);
    win = -1;
    for (int k = 0; k < n; k++) begin
      j = (m.ptr + k) % n;
      if (win < 0 && v[j]) win = j;
    end
    take = free && (win >= 0);
    er = take ? (3'b001 << win) : 3'b000;
    if (m.vis && rr[m.owner]) m.vis = 0;
    if (m.cnt > 0) begin
      m.cnt--;
      if (m.cnt == 0) begin m.vis = 1; m.out = m.p_out; m.zero = m.p_zero; m.ovf = m.p_ovf; end
    end
    if (take) begin
      op = ops[5*win +: 5];
      mdl_alu(op, a[32*win +: 32], b[32*win +: 32], y, z, o);
      lat = (op == OP_MUL || op == OP_REM || op == OP_REMU) ? slat : 1;
      m.owner = win;
      if (lat == 1) begin m.vis = 1; m.out = y; m.zero = z; m.ovf = o; end
      else begin m.cnt = lat - 1; m.p_out = y; m.p_zero = z; m.p_ovf = o; end
      m.ptr = (win + 1) % n;
    end
    mo = m;
  endfunction

  mdl_t m2, m3;
  bit   mv = 0;

  always @(negedge clk) begin
    mdl_t nx2, nx3;
    logic [2:0] er2, er3;
    mstep(m2, 2, 4, {1'b0, v2}, {5'b0, op2}, {32'b0, a2}, {32'b0, b2}, {1'b0, rr2}, nx2, er2);
    mstep(m3, 3, 2, v3, op3, a3, b3, rr3, nx3, er3);
    if (mv) begin
      chk("rdy2", 32'(rdy2), 32'(er2[1:0]));
      chk("vld2", 32'(vld2), m2.vis ? (32'd1 << m2.owner) : 32'd0);
      chk("out2", out2, m2.out);
      chk("zero2", 32'(zero2), 32'(m2.zero));
      chk("ovf2", 32'(ovf2), 32'(m2.ovf));
      chk("rdy3", 32'(rdy3), 32'(er3));
      chk("vld3", 32'(vld3), m3.vis ? (32'd1 << m3.owner) : 32'd0);
      chk("out3", out3, m3.out);
      chk("zero3", 32'(zero3), 32'(m3.zero));
      chk("ovf3", 32'(ovf3), 32'(m3.ovf));
    end
    if (reset) begin m2 = mreset(); m3 = mreset(); mv = 1; end
    else begin m2 = nx2; m3 = nx3; end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set2(input int i, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    op2[5*i +: 5] = op; a2[32*i +: 32] = a; b2[32*i +: 32] = b;
  endtask

  task automatic set3(input int i, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    op3[5*i +: 5] = op; a3[32*i +: 32] = a; b3[32*i +: 32] = b;
  endtask

  function automatic logic [4:0] rnd_op();
    if ($urandom_range(0, 19) == 0) return 5'd31;
    return 5'($urandom_range(0, 15));
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hffff_ffff;
      3, 4:    return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] y;
    bit z, o;
    logic [1:0] e;
    logic [1:0] acc2;
    logic [2:0] acc3;

    // model pins
    mdl_alu(OP_ADD, 32'd5, 32'd7, y, z, o);          chk("m_add", y, 32'd12);
    mdl_alu(OP_MUL, 32'd6, 32'd7, y, z, o);          chk("m_mul", y, 32'd42);
    mdl_alu(OP_REM, 32'hffff_fff9, 32'd3, y, z, o);  chk("m_rem", y, 32'hffff_ffff);
    mdl_alu(OP_REMU, 32'd9, 32'd0, y, z, o);         chk("m_remu0", y, 32'd9);
    mdl_alu(OP_ADD, 32'h7fff_ffff, 32'd1, y, z, o);  chk("m_ovf", 32'(o), 32'd1);
    mdl_alu(5'd31, 32'd3, 32'd4, y, z, o);           chk("m_unk", {y[30:0], z}, 32'd1);

    // reset state
    repeat (2) tick();
    reset = 0;
    chk("rst_vld", 32'(vld2), 0);
    chk("rst_out", out2, 0);
    chk("rst_rdy", 32'(rdy2), 0);

    // single fast op
    rr2 = 2'b11;
    set2(0, OP_ADD, 5, 7); v2 = 2'b01; #1;
    chk("add_rdy", 32'(rdy2), 32'b01);
    tick(); v2 = 2'b00; #1;
    chk("add_vld", 32'(vld2), 32'b01);
    chk("add_out", out2, 32'd12);
    chk("add_zero", 32'(zero2), 0);

    // contention from rr_ptr=0
    reset = 1; tick(); reset = 0;
    set2(0, OP_SUB, 9, 9); set2(1, OP_OR, 3, 4); v2 = 2'b11; #1;
    chk("cont_rdy0", 32'(rdy2), 32'b01);
    tick(); v2 = 2'b10; #1;
    chk("cont_vld0", 32'(vld2), 32'b01);
    chk("cont_out0", out2, 0);
    chk("cont_zero0", 32'(zero2), 1);
    chk("cont_rdy1", 32'(rdy2), 32'b10);
    tick(); v2 = 2'b11; #1;
    chk("cont_vld1", 32'(vld2), 32'b10);
    chk("cont_out1", out2, 32'd7);
    e = 2'b01;
    for (int c = 0; c < 6; c++) begin
      chk("alt_rdy", 32'(rdy2), 32'(e));
      tick();
      e = {e[0], e[1]};
    end
    v2 = 2'b00; tick(); tick();

    // slow op with a stalled competitor
    reset = 1; tick(); reset = 0;
    set2(1, OP_MUL, 6, 7); v2 = 2'b10; #1;
    chk("mul_rdy", 32'(rdy2), 32'b10);
    tick(); set2(0, OP_ADD, 1, 2); v2 = 2'b01; #1;
    for (int c = 1; c < 4; c++) begin
      chk("mul_stall_rdy", 32'(rdy2), 0);
      chk("mul_stall_vld", 32'(vld2), 0);
      tick();
    end
    chk("mul_vld", 32'(vld2), 32'b10);
    chk("mul_out", out2, 32'd42);
    chk("mul_rdy0", 32'(rdy2), 32'b01);
    tick(); v2 = 2'b00; #1;
    chk("mul_next", out2, 32'd3);
    tick();

    // back-pressure and owner isolation
    rr2 = 2'b00;
    set2(0, OP_ADD, 1, 1); v2 = 2'b01; #1;
    tick(); v2 = 2'b10; set2(1, OP_XOR, 5, 3); rr2 = 2'b10; #1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_vld", 32'(vld2), 32'b01);
      chk("bp_out", out2, 32'd2);
      chk("bp_rdy", 32'(rdy2), 0);
      tick();
    end
    rr2 = 2'b01; #1;
    chk("bp_release", 32'(rdy2), 32'b10);
    tick(); v2 = 2'b00; #1;
    chk("bp_vld1", 32'(vld2), 32'b10);
    chk("bp_out1", out2, 32'd6);
    rr2 = 2'b11; tick();

    // reset while BUSY
    set2(0, OP_MUL, 3, 3); v2 = 2'b01; #1;
    tick(); v2 = 2'b00;
    tick();
    reset = 1; tick(); reset = 0;
    chk("rb_out", out2, 0);
    for (int c = 0; c < 5; c++) begin
      chk("rb_vld", 32'(vld2), 0);
      tick();
    end
    set2(0, OP_ADD, 1, 1); set2(1, OP_ADD, 2, 2); v2 = 2'b11; #1;
    chk("rb_ptr", 32'(rdy2), 32'b01);
    tick(); v2 = 2'b00; tick(); tick();

    // NREQ=3 pointer wrap 2 -> 0
    set3(2, OP_ADD, 2, 2); v3 = 3'b100; #1;
    chk("w_rdy2", 32'(rdy3), 32'b100);
    tick(); set3(0, OP_ADD, 1, 0); set3(1, OP_ADD, 1, 1); v3 = 3'b011; #1;
    chk("w_vld2", 32'(vld3), 32'b100);
    chk("w_out2", out3, 32'd4);
    chk("w_rdy0", 32'(rdy3), 32'b001);
    tick(); v3 = 3'b010; #1;
    chk("w_vld0", 32'(vld3), 32'b001);
    chk("w_out0", out3, 32'd1);
    tick(); v3 = 3'b000; tick(); tick();

    // randomized traffic; requesters hold until accepted
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      acc2 = v2 & rdy2;
      acc3 = v3 & rdy3;
      @(posedge clk); #1;
      reset = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < 2; i++)
        if (!v2[i] || acc2[i]) begin
          v2[i] = ($urandom_range(0, 2) != 0);
          set2(i, rnd_op(), rnd_opnd(), rnd_opnd());
        end
      for (int i = 0; i < 3; i++)
        if (!v3[i] || acc3[i]) begin
          v3[i] = ($urandom_range(0, 2) != 0);
          set3(i, rnd_op(), rnd_opnd(), rnd_opnd());
        end
      for (int i = 0; i < 2; i++) rr2[i] = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 3; i++) rr3[i] = ($urandom_range(0, 3) != 0);
    end
    reset = 0;
    v2 = '0; v3 = '0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
